gcd_core: RTL
=============

Name: gcd_core

Overview:
Iterative subtraction-based Euclid GCD engine that sits directly downstream of the request-issuing master.
- Accepts an operand pair on a request and raises busy while computing.
- Returns the result with a one-cycle valid pulse.
- Holds busy until the result has been presented, so the master zeroes its operand outputs and cannot restart the engine mid-computation.

Parameters:
- WIDTH, 4: operand and result width in bits.

Ports:
- clk_i, input, 1: clock; all state updates on the rising edge.
- rst_i, input, 1: synchronous active-high reset.
- a_i, input, WIDTH: operand A, sampled only on the accept edge.
- b_i, input, WIDTH: operand B, sampled only on the accept edge.
- req_i, input, 1: request; level-sensitive, honoured only in IDLE.
- busy_o, output, 1: high while in CALC or DONE.
- valid_o, output, 1: high for exactly one cycle, in DONE.
- result_o, output, WIDTH: GCD value; meaningful while valid_o is high, held afterwards until the next accept.
- iter_o, output, WIDTH: number of subtraction steps used by the last computation; updated together with result_o.

Behaviour:
- Reset (rst_i sampled high on a clock edge):
  - state returns to IDLE.
  - busy_o=0, valid_o=0, result_o=0, iter_o=0.
  - Internal operand registers and step counter are cleared.
  - Reset takes priority over every other event, including mid-CALC and during DONE; an in-flight computation is discarded with no valid pulse.
- States: IDLE, CALC, DONE. The state is held in a register; busy_o and valid_o are decoded from the state (Moore outputs).
- IDLE:
  - busy_o=0.
  - Accept edge = clock edge with state IDLE and req_i=1. On it, a_i and b_i are latched into regA/regB and the step count is cleared.
  - If either operand is zero: go directly to DONE with result = a_i OR b_i (gcd(x,0)=x, gcd(0,0)=0) and 0 steps.
  - Otherwise go to CALC.
  - req_i=0: stay in IDLE.
- CALC, one action per clock edge:
  - regA==regB: result_o<=regA, iter_o<=count, go to DONE.
  - regA>regB: regA<=regA-regB, count+1.
  - regB>regA: regB<=regB-regA, count+1.
  - All arithmetic is unsigned, WIDTH bits; no underflow is possible because the larger operand is always the minuend.
  - The count cannot overflow: at most 2^WIDTH-2 steps.
- DONE:
  - valid_o=1 and busy_o=1 for exactly one cycle, then IDLE unconditionally.
  - req_i is ignored in DONE.
- Latency: with N subtractions, valid_o is high in the cycle following edge N+1 after the accept edge. Equal operands give N=0 (valid after edge 1); a zero operand gives valid in the cycle directly after the accept edge.
- req_i in CALC or DONE is ignored; there is no queuing.
- If req_i is still high in IDLE after DONE, a new computation is accepted on that edge, which gives a minimum one idle cycle between results.
- Operand changes on a_i/b_i after the accept edge have no effect.
- Throughput: one computation at a time; worst case for WIDTH=4 is gcd(15,1), with 14 steps and valid after edge 15.

Decomposition:
- Package gcd_pkg:
  - state enum gcd_state_e {IDLE, CALC, DONE}.
  - localparam GCD_WIDTH=4, shared by master, core and bench.
- One sub-module, gcd_step (combinational):
  - Inputs: regA, regB.
  - Outputs: next regA, next regB, eq flag, step flag.
  - Instantiated once in gcd_core.
- The FSM, counter and output registers stay in gcd_core.

Test Plan:
- Reset, then a=6, b=4, req held one cycle -> busy_o rises after the accept edge; valid_o pulses after edge 3; result_o=2, iter_o=2; busy_o low the following cycle.
- a=15, b=1 -> valid_o after edge 15, result_o=1, iter_o=14; req_i toggling during CALC causes no restart.
- a=9, b=9 -> valid_o after edge 1, result_o=9, iter_o=0.
- a=0, b=12, then a=0, b=0 -> valid_o in the cycle after accept with result_o=12, then 0; busy_o high for exactly one cycle each time.
- rst_i asserted during CALC of a=14, b=10 -> next cycle IDLE, busy_o=0, valid_o=0, result_o=0, no valid pulse; a following request a=8, b=12 yields result_o=4.
- req_i held high continuously with a=12, b=8 -> back-to-back computations, each valid pulse result_o=4, separated by at least one IDLE cycle with busy_o=0.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD engine, its master and the bench.
package gcd_pkg;

    localparam int GCD_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } gcd_state_e;

endpackage : gcd_pkg

// File: rtl/gcd_if.sv
// Request/result bundle between the issuing master and the GCD engine.
interface gcd_if
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
);
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             req_i;
    logic             busy_o;
    logic             valid_o;
    logic [WIDTH-1:0] result_o;
    logic [WIDTH-1:0] iter_o;

    modport master (
        output a_i, b_i, req_i,
        input  busy_o, valid_o, result_o, iter_o
    );

    modport slave (
        input  a_i, b_i, req_i,
        output busy_o, valid_o, result_o, iter_o
    );
endinterface : gcd_if

// File: rtl/gcd_step.sv
// One Euclid subtraction step: the larger operand loses the smaller one.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic [WIDTH-1:0] rega_i,
    input  logic [WIDTH-1:0] regb_i,
    output logic [WIDTH-1:0] rega_nxt_o,
    output logic [WIDTH-1:0] regb_nxt_o,
    output logic             eq_o,
    output logic             step_o
);

    // Larger operand is always the minuend, so the subtraction never wraps.
    always_comb begin
        rega_nxt_o = rega_i;
        regb_nxt_o = regb_i;
        eq_o       = (rega_i == regb_i);
        step_o     = !eq_o;
        if (rega_i > regb_i) begin
            rega_nxt_o = rega_i - regb_i;
        end else if (regb_i > rega_i) begin
            regb_nxt_o = regb_i - rega_i;
        end
    end

endmodule : gcd_step

// File: rtl/gcd_core.sv
// Iterative subtraction GCD engine with busy/valid handshake.
//
// state | meaning
// IDLE  | waiting for req_i; operands latched on the accept edge
// CALC  | one subtraction per edge until the operands match
// DONE  | result presented, valid_o high for this single cycle
module gcd_core
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic  clk_i,
    input  logic  rst_i,
    gcd_if.slave  bus
);

    gcd_state_e       state_q,  state_d;
    logic [WIDTH-1:0] rega_q,   rega_d;
    logic [WIDTH-1:0] regb_q,   regb_d;
    logic [WIDTH-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] iter_q,   iter_d;

    logic [WIDTH-1:0] rega_nxt;
    logic [WIDTH-1:0] regb_nxt;
    logic             eq;
    logic             step;

    gcd_step #(.WIDTH(WIDTH)) u_step (
        .rega_i     (rega_q),
        .regb_i     (regb_q),
        .rega_nxt_o (rega_nxt),
        .regb_nxt_o (regb_nxt),
        .eq_o       (eq),
        .step_o     (step)
    );

    // State and datapath registers; reset discards any in-flight computation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rega_q   <= '0;
            regb_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            iter_q   <= '0;
        end else begin
            state_q  <= state_d;
            rega_q   <= rega_d;
            regb_q   <= regb_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            iter_q   <= iter_d;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d  = state_q;
        rega_d   = rega_q;
        regb_d   = regb_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        iter_d   = iter_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_i) begin
                    rega_d = bus.a_i;
                    regb_d = bus.b_i;
                    cnt_d  = '0;
                    // gcd(x,0)=x and gcd(0,0)=0 both reduce to a OR b.
                    if ((bus.a_i == '0) || (bus.b_i == '0)) begin
                        result_d = bus.a_i | bus.b_i;
                        iter_d   = '0;
                        state_d  = DONE;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                if (eq) begin
                    result_d = rega_q;
                    iter_d   = cnt_q;
                    state_d  = DONE;
                end else if (step) begin
                    rega_d = rega_nxt;
                    regb_d = regb_nxt;
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        bus.busy_o   = (state_q == CALC) || (state_q == DONE);
        bus.valid_o  = (state_q == DONE);
        bus.result_o = result_q;
        bus.iter_o   = iter_q;
    end

endmodule : gcd_core
